// File: rtl/signal_sequence_monitor_if.sv
// Lamp inputs and status outputs of the traffic light sequence monitor.
// master drives lamps/clear and reads status; slave is the monitor.
interface signal_sequence_monitor_if;
  logic [3:0]  red;
  logic [3:0]  yellow;
  logic [3:0]  green;
  logic        clear;
  logic [1:0]  active_lane;
  logic        lane_valid;
  logic [3:0]  phase_secs;
  logic [3:0]  err_onehot;
  logic [3:0]  err_transition;
  logic        err_conflict;
  logic        err_order;
  logic        err_timeout;
  logic        fault;
  logic [15:0] rotations;

  modport master (
    output red, yellow, green, clear,
    input  active_lane, lane_valid, phase_secs,
    input  err_onehot, err_transition, err_conflict,
    input  err_order, err_timeout, fault, rotations
  );

  modport slave (
    input  red, yellow, green, clear,
    output active_lane, lane_valid, phase_secs,
    output err_onehot, err_transition, err_conflict,
    output err_order, err_timeout, fault, rotations
  );
endinterface

// File: rtl/signal_sequence_monitor.sv
// Receiving-end checker for a 4-lane traffic light controller.
// Rotation counter enabled by SIGNAL_MONITOR_ROTATION_COUNT_EN.
module signal_sequence_monitor #(
  parameter int TICK_CYCLES    = 100000000,
  parameter int MAX_GREEN_SECS = 6
) (
  input logic clk,
  input logic reset,
  signal_sequence_monitor_if.slave bus
);
  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {
    C_RED,
    C_YEL,
    C_GRN,
    C_ILL
  } colour_e;

  function automatic colour_e decode(
    input logic r, input logic y, input logic g
  );
    case ({r, y, g})
      3'b100:  decode = C_RED;
      3'b010:  decode = C_YEL;
      3'b001:  decode = C_GRN;
      default: decode = C_ILL;
    endcase
  endfunction

  function automatic logic step_ok(
    input colour_e p, input colour_e c
  );
    step_ok = (p == c)
      || (p == C_RED && c == C_YEL)
      || (p == C_YEL && c == C_GRN)
      || (p == C_GRN && c == C_RED);
  endfunction

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    cur_r, cur_y, cur_g;
  logic [3:0]    prev_r, prev_y, prev_g;
  logic          cur_vld;
  logic          primed;
  logic          order_primed;
  logic [1:0]    last_lane;

  logic [1:0]    active_q;
  logic          valid_q;
  logic [3:0]    phase_q;
  logic [3:0]    onehot_q;
  logic [3:0]    trans_q;
  logic          conflict_q;
  logic          order_q;
  logic          timeout_q;
  logic          fault_q;

  logic [3:0]    oh_hit;
  logic [3:0]    tr_hit;
  logic          g_one;
  logic          g_multi;
  logic [1:0]    g_idx;
  logic          lane_ok;
  logic          lane_change;
  logic          order_bad;
  logic [3:0]    phase_nxt;
  logic          to_hit;

  assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

  // cur_vld masks the reset-valued sample so it is never decoded
  always_comb begin
    oh_hit  = '0;
    tr_hit  = '0;
    g_idx   = 2'd0;
    g_one   = (cur_g != 4'd0)
      && ((cur_g & (cur_g - 4'd1)) == 4'd0);
    g_multi = (cur_g & (cur_g - 4'd1)) != 4'd0;
    for (int i = 0; i < 4; i++) begin
      oh_hit[i] = cur_vld
        && decode(cur_r[i], cur_y[i], cur_g[i]) == C_ILL;
      tr_hit[i] = cur_vld && primed
        && decode(cur_r[i], cur_y[i], cur_g[i]) != C_ILL
        && decode(prev_r[i], prev_y[i], prev_g[i]) != C_ILL
        && !step_ok(decode(prev_r[i], prev_y[i], prev_g[i]),
                    decode(cur_r[i], cur_y[i], cur_g[i]));
      if (cur_g[i]) g_idx = 2'(i);
    end
    lane_ok     = cur_vld && g_one;
    lane_change = lane_ok
      && (!order_primed || g_idx != last_lane);
    order_bad   = lane_ok && order_primed
      && g_idx != last_lane
      && g_idx != last_lane + 2'd1;
    phase_nxt = phase_q;
    if (bus.clear)
      phase_nxt = 4'd0;
    else if (lane_change)
      phase_nxt = 4'd0;
    else if (lane_ok && tick && phase_q != 4'hF)
      phase_nxt = phase_q + 4'd1;
    to_hit = phase_nxt >= 4'(MAX_GREEN_SECS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt     <= '0;
      cur_r        <= '0;
      cur_y        <= '0;
      cur_g        <= '0;
      prev_r       <= '0;
      prev_y       <= '0;
      prev_g       <= '0;
      cur_vld      <= 1'b0;
      primed       <= 1'b0;
      order_primed <= 1'b0;
      last_lane    <= 2'd0;
      active_q     <= 2'd0;
      valid_q      <= 1'b0;
      phase_q      <= 4'd0;
      onehot_q     <= '0;
      trans_q      <= '0;
      conflict_q   <= 1'b0;
      order_q      <= 1'b0;
      timeout_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      cur_r    <= bus.red;
      cur_y    <= bus.yellow;
      cur_g    <= bus.green;
      cur_vld  <= 1'b1;
      prev_r   <= cur_r;
      prev_y   <= cur_y;
      prev_g   <= cur_g;

      if (bus.clear) primed <= 1'b0;
      else if (cur_vld) primed <= 1'b1;

      if (bus.clear) order_primed <= 1'b0;
      else if (lane_ok) order_primed <= 1'b1;

      if (lane_ok) begin
        last_lane <= g_idx;
        active_q  <= g_idx;
      end
      valid_q <= lane_ok;
      phase_q <= phase_nxt;

      // a new error in the clear cycle still lands
      onehot_q   <= (bus.clear ? 4'd0 : onehot_q) | oh_hit;
      trans_q    <= (bus.clear ? 4'd0 : trans_q) | tr_hit;
      conflict_q <= (!bus.clear && conflict_q)
        || (cur_vld && g_multi);
      order_q    <= (!bus.clear && order_q) || order_bad;
      timeout_q  <= (!bus.clear && timeout_q) || to_hit;
      fault_q    <= |{onehot_q, trans_q, conflict_q,
                      order_q, timeout_q};
    end
  end

  assign bus.active_lane    = active_q;
  assign bus.lane_valid     = valid_q;
  assign bus.phase_secs     = phase_q;
  assign bus.err_onehot     = onehot_q;
  assign bus.err_transition = trans_q;
  assign bus.err_conflict   = conflict_q;
  assign bus.err_order      = order_q;
  assign bus.err_timeout    = timeout_q;
  assign bus.fault          = fault_q;

`ifdef SIGNAL_MONITOR_ROTATION_COUNT_EN
  logic [15:0] rot_q;
  logic        wrap_step;

  assign wrap_step = lane_ok && order_primed
    && last_lane == 2'd3 && g_idx == 2'd0;

  always_ff @(posedge clk) begin
    if (reset || bus.clear)
      rot_q <= '0;
    else if (wrap_step && !order_q)
      rot_q <= rot_q + 16'd1;
  end

  assign bus.rotations = rot_q;
`else
  assign bus.rotations = '0;
`endif
endmodule

// File: tb/tb_signal_sequence_monitor.sv
// Directed scoreboard bench for signal_sequence_monitor.
// TICK_CYCLES=10, MAX_GREEN_SECS=6.
module tb_signal_sequence_monitor;
  typedef struct packed {
    logic [1:0]  al;
    logic        lv;
    logic [3:0]  ph;
    logic [3:0]  oh;
    logic [3:0]  tr;
    logic        cf;
    logic        od;
    logic        tmo;
    logic        ft;
    logic [15:0] rot;
  } st_t;

`ifdef SIGNAL_MONITOR_ROTATION_COUNT_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  reset;
  int    cyc = 0;
  int    e0 = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    sb_due[$];
  st_t   sb_exp[$];
  string sb_tag[$];
  st_t   ex;
  st_t   obs;
  int    c0;

  signal_sequence_monitor_if bus();

  signal_sequence_monitor #(
    .TICK_CYCLES(10),
    .MAX_GREEN_SECS(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb_due.size() > 0 && sb_due[0] <= cyc) begin
      obs = {bus.active_lane, bus.lane_valid, bus.phase_secs,
             bus.err_onehot, bus.err_transition,
             bus.err_conflict, bus.err_order,
             bus.err_timeout, bus.fault, bus.rotations};
      vectors++;
      assert (obs === sb_exp[0]) else begin
        miscompares++;
        $error("FAIL %s obs=%h exp=%h",
               sb_tag[0], obs, sb_exp[0]);
      end
      void'(sb_due.pop_front());
      void'(sb_exp.pop_front());
      void'(sb_tag.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align(input int k);
    while (((cyc - e0) % 10) != k) step(1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic put(input logic [3:0] y, input logic [3:0] g);
    bus.red    = ~(y | g);
    bus.yellow = y;
    bus.green  = g;
  endtask

  task automatic push(input int d, input string tag);
    sb_due.push_back(cyc + d);
    sb_exp.push_back(ex);
    sb_tag.push_back(tag);
  endtask

  initial begin
    reset     = 1'b1;
    bus.clear = 1'b0;
    put(4'h0, 4'h0);
    ex = '0;
    step(3);
    push(0, "reset");

    // legal rotation: 10 cycles yellow, 50 cycles green per lane
    reset = 1'b0;
    e0    = cyc;
    step(9);
    for (int p = 0; p < 13; p++) begin
      put(4'(1 << (p % 4)), 4'h0);
      if (p > 0) begin
        ex.lv = 1'b0;
        push(2, "yellow_hold");
      end
      step(10);
      put(4'h0, 4'(1 << (p % 4)));
      step(49);
      ex.al  = 2'(p % 4);
      ex.lv  = 1'b1;
      ex.ph  = 4'd5;
      ex.rot = ROT_ON ? 16'(p / 4) : 16'd0;
      push(2, "phase_end");
      step(1);
    end

    // one-cycle illegal colour on lane 2
    put(4'h0, 4'h0);
    ex.lv = 1'b0;
    step(3);
    bus.red    = 4'hF;
    bus.yellow = 4'b0100;
    bus.green  = 4'h0;
    ex.oh = 4'b0100;
    push(2, "onehot");
    ex.ft = 1'b1;
    push(3, "onehot_fault");
    step(1);
    put(4'h0, 4'h0);
    step(5);
    push(0, "onehot_sticky");

    bus.clear = 1'b1;
    ex.oh  = 4'h0;
    ex.ph  = 4'd0;
    ex.rot = 16'd0;
    push(1, "clear");
    ex.ft = 1'b0;
    push(2, "clear_fault");
    step(1);
    bus.clear = 1'b0;
    step(2);

    // conflict, order jump 1->3, illegal YEL->RED on lane 3
    align(0);
    put(4'b0010, 4'h0);
    step(1);
    put(4'h0, 4'b0010);
    ex.al = 2'd1;
    ex.lv = 1'b1;
    push(2, "first_green");
    step(1);
    put(4'b1001, 4'b0010);
    step(1);
    put(4'h0, 4'b1001);
    ex.lv = 1'b0;
    ex.cf = 1'b1;
    push(2, "conflict");
    step(1);
    put(4'h0, 4'b1000);
    ex.al = 2'd3;
    ex.lv = 1'b1;
    ex.od = 1'b1;
    ex.ft = 1'b1;
    push(2, "order");
    step(1);
    put(4'h0, 4'h0);
    step(1);
    put(4'b1000, 4'h0);
    step(1);
    put(4'h0, 4'h0);
    ex.lv = 1'b0;
    ex.tr = 4'b1000;
    push(2, "yel_to_red");
    step(4);

    // clear lands in the same cycle as a new conflict
    put(4'b0110, 4'h0);
    step(1);
    put(4'h0, 4'b0110);
    step(1);
    bus.clear = 1'b1;
    put(4'h0, 4'h0);
    ex.tr = 4'h0;
    ex.od = 1'b0;
    push(1, "clear_vs_conflict");
    step(1);
    bus.clear = 1'b0;
    step(1);
    bus.clear = 1'b1;
    ex.cf = 1'b0;
    push(1, "clear_all");
    ex.ft = 1'b0;
    push(2, "clear_all_fault");
    step(1);
    bus.clear = 1'b0;
    step(2);

    // lane 0 held green for more than 8 ticks
    align(0);
    c0 = cyc;
    put(4'b0001, 4'h0);
    step(1);
    put(4'h0, 4'b0001);
    ex.al = 2'd0;
    ex.lv = 1'b1;
    push(2, "to_start");
    wait_until(c0 + 57);
    ex.ph = 4'd5;
    push(2, "to_before");
    ex.ph  = 4'd6;
    ex.tmo = 1'b1;
    push(3, "to_hit");
    ex.ft = 1'b1;
    push(4, "to_fault");
    wait_until(c0 + 78);
    ex.ph = 4'd8;
    push(2, "phase_8");
    wait_until(c0 + 84);
    put(4'h0, 4'h0);
    ex.lv = 1'b0;
    push(11, "phase_hold");
    wait_until(c0 + 96);

    // reset in the middle of a lane 1 green
    put(4'b0010, 4'h0);
    step(1);
    put(4'h0, 4'b0010);
    step(3);
    reset = 1'b1;
    ex = '0;
    push(1, "reset_mid");
    step(1);
    reset = 1'b0;
    e0 = cyc;
    put(4'h0, 4'b1000);
    ex.al = 2'd3;
    ex.lv = 1'b1;
    push(2, "post_reset");
    step(1);
    push(2, "post_reset_2");
    step(6);

    vectors++;
    if (sb_due.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain left=%0d required=0",
               sb_due.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
